// File: rtl/cursor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cursor_pkg
// Description : Screen geometry, accumulator limits, FSM state encoding and
//               the coordinate clamp helper shared by the cursor tracker and
//               the coordinate calculator.
// Revision    : 1.0 - initial release
// ============================================================================
package cursor_pkg;

    // Visible screen geometry and sprite half-extent (clamp margin)
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int HALF_SIZE = 35;

    // Delta accumulator width and its saturation limits, expressed in the
    // one-bit-wider domain used for the pre-saturation sum
    localparam int ACC_W = 12;
    localparam int SUM_W = 13;
    localparam logic signed [SUM_W-1:0] ACC_MAX_EXT = 13'sd2047;
    localparam logic signed [SUM_W-1:0] ACC_MIN_EXT = -13'sd2048;

    // Frame update sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Clamp a signed position sum into [lo, hi]; the result always fits in
    // the 10-bit coordinate space because hi < 1024.
    function automatic logic [9:0] clamp_coord(
        input logic signed [SUM_W-1:0] v,
        input logic signed [SUM_W-1:0] lo,
        input logic signed [SUM_W-1:0] hi
    );
        logic signed [SUM_W-1:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r[9:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_accum.sv
`default_nettype none
// ============================================================================
// Module      : sat_accum
// Description : One saturating signed accumulator with a clear input. When
//               clear and add coincide the delta lands in the cleared value,
//               so no delta is lost across a clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_accum
    import cursor_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_add,
    input  logic signed [ACC_W-1:0] i_delta,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [SUM_W-1:0] w_base;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_next;

    // Widen by one bit, add, then saturate back into the accumulator range
    always_comb begin
        w_base = i_clr ? '0 : {r_acc[ACC_W-1], r_acc};
        w_sum  = w_base + {i_delta[ACC_W-1], i_delta};
        if (w_sum > ACC_MAX_EXT) begin
            w_next = ACC_MAX_EXT[ACC_W-1:0];
        end else if (w_sum < ACC_MIN_EXT) begin
            w_next = ACC_MIN_EXT[ACC_W-1:0];
        end else begin
            w_next = w_sum[ACC_W-1:0];
        end
    end

    // Accumulator register: add (on top of a possible clear) or plain clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= w_next;
        end else if (i_clr) begin
            r_acc <= '0;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/cursor_position_tracker.sv
`default_nettype none
// ============================================================================
// Module      : cursor_position_tracker
// Description : Accumulates mouse packet deltas between frames and, once per
//               synchronised frame tick, applies them to the cursor centre
//               with clamping to the visible area minus the sprite margin.
// Revision    : 1.0 - initial release
// ============================================================================
module cursor_position_tracker #(
    parameter int SCREEN_W  = cursor_pkg::SCREEN_W,
    parameter int SCREEN_H  = cursor_pkg::SCREEN_H,
    parameter int HALF_SIZE = cursor_pkg::HALF_SIZE,
    parameter int START_X   = 320,
    parameter int START_Y   = 240
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       pkt_valid,
    output logic       pkt_ready,
    input  logic [8:0] pkt_dx,
    input  logic [8:0] pkt_dy,
    input  logic [2:0] pkt_btn,
    output logic [9:0] curX,
    output logic [9:0] curY,
    output logic       btn_left,
    output logic       btn_right,
    output logic       click_pulse,
    output logic       frame_update
);

    import cursor_pkg::*;

    localparam logic signed [SUM_W-1:0] c_X_MIN = SUM_W'(HALF_SIZE);
    localparam logic signed [SUM_W-1:0] c_X_MAX = SUM_W'(SCREEN_W - 1 - HALF_SIZE);
    localparam logic signed [SUM_W-1:0] c_Y_MIN = SUM_W'(HALF_SIZE);
    localparam logic signed [SUM_W-1:0] c_Y_MAX = SUM_W'(SCREEN_H - 1 - HALF_SIZE);
    localparam logic [9:0]              c_START_X = 10'(START_X);
    localparam logic [9:0]              c_START_Y = 10'(START_Y);

    state_t                  r_state;
    logic                    r_sync1;
    logic                    r_sync2;
    logic                    r_sync_d;
    logic                    r_pkt_ready;
    logic signed [SUM_W-1:0] r_sum_x;
    logic signed [SUM_W-1:0] r_sum_y;
    logic [9:0]              r_cur_x;
    logic [9:0]              r_cur_y;
    logic                    r_frame_update;
    logic                    r_btn_left;
    logic                    r_btn_right;
    logic                    r_click;

    logic                    w_tick;
    logic                    w_accept;
    logic                    w_clr;
    logic signed [ACC_W-1:0] w_dx_ext;
    logic signed [ACC_W-1:0] w_dy_neg;
    logic signed [ACC_W-1:0] w_acc_x;
    logic signed [ACC_W-1:0] w_acc_y;
    logic signed [SUM_W-1:0] w_sum_x;
    logic signed [SUM_W-1:0] w_sum_y;
    logic                    w_unused_mid;

    // Middle button is carried in the packet but has no consumer here
    assign w_unused_mid = pkt_btn[2];

    assign w_tick   = r_sync2 & ~r_sync_d;
    assign w_accept = pkt_valid & r_pkt_ready;
    assign w_clr    = (r_state == APPLY);

    // Screen Y grows downward, so a positive (up) dy decreases Y
    assign w_dx_ext = {{(ACC_W-9){pkt_dx[8]}}, pkt_dx};
    assign w_dy_neg = -{{(ACC_W-9){pkt_dy[8]}}, pkt_dy};

    assign w_sum_x = {{(SUM_W-10){1'b0}}, r_cur_x} + {w_acc_x[ACC_W-1], w_acc_x};
    assign w_sum_y = {{(SUM_W-10){1'b0}}, r_cur_y} + {w_acc_y[ACC_W-1], w_acc_y};

    sat_accum u_acc_x (
        .clk     (Clk),
        .rst_n   (Reset),
        .i_clr   (w_clr),
        .i_add   (w_accept),
        .i_delta (w_dx_ext),
        .o_acc   (w_acc_x)
    );

    sat_accum u_acc_y (
        .clk     (Clk),
        .rst_n   (Reset),
        .i_clr   (w_clr),
        .i_add   (w_accept),
        .i_delta (w_dy_neg),
        .o_acc   (w_acc_y)
    );

    // Two-flop synchroniser for the frame strobe plus an edge-detect flop
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync1  <= frame_clk;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    // Frame sequencer: latch sums in APPLY, publish clamped position in COMMIT
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state        <= IDLE;
            r_pkt_ready    <= 1'b0;
            r_sum_x        <= '0;
            r_sum_y        <= '0;
            r_cur_x        <= c_START_X;
            r_cur_y        <= c_START_Y;
            r_frame_update <= 1'b0;
        end else begin
            r_frame_update <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        r_state     <= APPLY;
                        r_pkt_ready <= 1'b0;
                    end else begin
                        r_pkt_ready <= 1'b1;
                    end
                end
                APPLY: begin
                    r_sum_x     <= w_sum_x;
                    r_sum_y     <= w_sum_y;
                    r_state     <= COMMIT;
                    r_pkt_ready <= 1'b1;
                end
                COMMIT: begin
                    r_cur_x        <= clamp_coord(r_sum_x, c_X_MIN, c_X_MAX);
                    r_cur_y        <= clamp_coord(r_sum_y, c_Y_MIN, c_Y_MAX);
                    r_frame_update <= 1'b1;
                    r_state        <= IDLE;
                    r_pkt_ready    <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_pkt_ready <= 1'b1;
                end
            endcase
        end
    end

    // Button state follows each accepted packet; left press yields one pulse
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_btn_left  <= 1'b0;
            r_btn_right <= 1'b0;
            r_click     <= 1'b0;
        end else begin
            r_click <= 1'b0;
            if (w_accept) begin
                r_btn_left  <= pkt_btn[0];
                r_btn_right <= pkt_btn[1];
                r_click     <= pkt_btn[0] & ~r_btn_left;
            end
        end
    end

    assign pkt_ready    = r_pkt_ready;
    assign curX         = r_cur_x;
    assign curY         = r_cur_y;
    assign btn_left     = r_btn_left;
    assign btn_right    = r_btn_right;
    assign click_pulse  = r_click;
    assign frame_update = r_frame_update;

endmodule
`default_nettype wire

// File: tb/tb_cursor_position_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_cursor_position_tracker
// Description : Self-checking bench for cursor_position_tracker. A reference
//               model accumulates packet deltas; each frame tick pushes the
//               expected position to a queue that is popped on frame_update.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cursor_position_tracker;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       pkt_valid;
    logic       pkt_ready;
    logic [8:0] pkt_dx;
    logic [8:0] pkt_dy;
    logic [2:0] pkt_btn;
    logic [9:0] curX;
    logic [9:0] curY;
    logic       btn_left;
    logic       btn_right;
    logic       click_pulse;
    logic       frame_update;

    int total = 0;
    int bad   = 0;
    int clicks = 0;

    logic [19:0] sb_q[$];

    // Reference model state
    int   m_ax, m_ay, m_cx, m_cy;
    logic m_left;

    cursor_position_tracker dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_dx       (pkt_dx),
        .pkt_dy       (pkt_dy),
        .pkt_btn      (pkt_btn),
        .curX         (curX),
        .curY         (curY),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .click_pulse  (click_pulse),
        .frame_update (frame_update)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input int exp);
        total++;
        if (got !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int sat12(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_ax = 0; m_ay = 0; m_cx = 320; m_cy = 240; m_left = 1'b0;
        sb_q.delete();
    endtask

    task automatic do_reset();
        @(posedge Clk); #1;
        Reset = 1'b0; frame_clk = 1'b0; pkt_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b1;
        model_reset();
        repeat (2) @(negedge Clk);
    endtask

    // Offer one packet, wait (bounded) for acceptance, update the model
    task automatic send_pkt(input int dx, input int dy, input logic [2:0] btn);
        int   n;
        logic exp_click;
        @(posedge Clk); #1;
        pkt_valid = 1'b1; pkt_dx = 9'(dx); pkt_dy = 9'(dy); pkt_btn = btn;
        n = 0;
        @(negedge Clk);
        while (!pkt_ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check_val("pkt_ready_wait", 32'(pkt_ready), 1);
        @(posedge Clk); #1;
        pkt_valid = 1'b0;
        exp_click = btn[0] & ~m_left;
        m_left    = btn[0];
        m_ax      = sat12(m_ax + dx);
        m_ay      = sat12(m_ay - dy);
        @(negedge Clk);
        check_val("click_pulse", 32'(click_pulse), int'(exp_click));
        check_val("btn_left", 32'(btn_left), int'(btn[0]));
        check_val("btn_right", 32'(btn_right), int'(btn[1]));
        if (click_pulse) clicks++;
    endtask

    // Raise the frame strobe and watch the update; optionally offer a packet
    // during APPLY so it stalls and is accepted in COMMIT
    task automatic do_tick(input bit inject, input int inj_dx);
        int fu_cnt;
        int first;
        logic [19:0] e;
        m_cx = clampi(m_cx + m_ax, 35, 604);
        m_cy = clampi(m_cy + m_ay, 35, 444);
        m_ax = 0; m_ay = 0;
        sb_q.push_back({10'(m_cx), 10'(m_cy)});
        fu_cnt = 0;
        first  = -1;
        @(posedge Clk); #1 frame_clk = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge Clk);
            if (frame_update) begin
                fu_cnt++;
                if (first < 0) first = c;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_val("curX", 32'(curX), int'(e[19:10]));
                    check_val("curY", 32'(curY), int'(e[9:0]));
                end else begin
                    check_val("extra_frame_update", 32'(frame_update), 0);
                end
            end
            if (inject) begin
                if (c == 4) begin
                    check_val("stall_ready_apply", 32'(pkt_ready), 0);
                    pkt_valid = 1'b1; pkt_dx = 9'(inj_dx); pkt_dy = 9'd0; pkt_btn = 3'b000;
                end
                if (c == 5) check_val("ready_commit", 32'(pkt_ready), 1);
                if (c == 6) begin
                    pkt_valid = 1'b0;
                    m_ax   = sat12(m_ax + inj_dx);
                    m_left = 1'b0;
                end
            end
        end
        check_val("frame_update_count", 32'(fu_cnt), 1);
        check_val("update_latency", 32'(first), 6);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        int fu_seen;
        Reset = 1'b0; frame_clk = 1'b0; pkt_valid = 1'b0;
        pkt_dx = '0; pkt_dy = '0; pkt_btn = '0;
        model_reset();

        // Reset state
        repeat (3) @(negedge Clk);
        check_val("rst_curX", 32'(curX), 320);
        check_val("rst_curY", 32'(curY), 240);
        check_val("rst_ready", 32'(pkt_ready), 0);
        check_val("rst_frame_update", 32'(frame_update), 0);
        check_val("rst_click", 32'(click_pulse), 0);
        check_val("rst_btns", 32'({btn_left, btn_right}), 0);
        @(posedge Clk); #1 Reset = 1'b1;
        @(negedge Clk);
        check_val("ready_before_clock", 32'(pkt_ready), 0);
        @(negedge Clk);
        check_val("ready_first_clock", 32'(pkt_ready), 1);
        check_val("no_frame_update_after_rst", 32'(frame_update), 0);

        // Basic move: +10 right, +5 up
        send_pkt(10, 5, 3'b000);
        do_tick(1'b0, 0);

        // Saturating accumulation then clamp at right edge
        for (int i = 0; i < 20; i++) send_pkt(255, 0, 3'b000);
        do_tick(1'b0, 0);

        // Large negative deltas from the start position
        do_reset();
        send_pkt(-256, -256, 3'b000);
        do_tick(1'b0, 0);

        // Packet held across a tick is applied on the following tick
        send_pkt(-4, 2, 3'b000);
        do_tick(1'b1, 7);
        do_tick(1'b0, 0);

        // Left button 0 -> 1 -> 1 -> 1 gives one click; right button tracked
        clicks = 0;
        send_pkt(0, 0, 3'b000);
        send_pkt(0, 0, 3'b001);
        send_pkt(0, 0, 3'b011);
        send_pkt(0, 0, 3'b001);
        check_val("click_count", 32'(clicks), 1);

        // Reset during COMMIT drops the pending sum
        send_pkt(50, -20, 3'b000);
        @(posedge Clk); #1 frame_clk = 1'b1;
        repeat (5) @(negedge Clk);
        check_val("pre_rst_ready_commit", 32'(pkt_ready), 1);
        Reset = 1'b0; frame_clk = 1'b0;
        #1;
        check_val("midrst_curX", 32'(curX), 320);
        check_val("midrst_curY", 32'(curY), 240);
        check_val("midrst_ready", 32'(pkt_ready), 0);
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;
        model_reset();
        fu_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            if (frame_update) fu_seen++;
        end
        check_val("midrst_no_update", 32'(fu_seen), 0);
        check_val("midrst_hold_curX", 32'(curX), 320);

        // Accumulators must also be clear: a tick with no packets keeps 320/240
        do_tick(1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
